posted_write_buffer: RTL and testbench



---
 rtl/posted_write_buffer.sv | 135 +++++++++++++
 tb/tb_posted_write_buffer.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/posted_write_buffer.sv
// Posted-write buffer: writes are acknowledged on entry to a small FIFO and drained
// to the RAM in order; reads wait for an empty FIFO and are forwarded to the RAM.
module posted_write_buffer #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 4,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic [ADDR_WIDTH-1:0]              up_address,
  input  logic                               up_rq,
  input  logic                               up_wr_ni,
  input  logic [DATA_WIDTH-1:0]              up_dataW,
  output logic                               up_ack,
  output logic [DATA_WIDTH-1:0]              up_dataR,
  output logic [ADDR_WIDTH-1:0]              dn_address,
  output logic                               dn_rq,
  output logic                               dn_wr_ni,
  output logic [DATA_WIDTH-1:0]              dn_dataW,
  input  logic                               dn_ack,
  input  logic [DATA_WIDTH-1:0]              dn_dataR,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    fill_level
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    WR_REQ  = 2'd1,
    RD_REQ  = 2'd2,
    RD_RESP = 2'd3
  } state_t;

  state_t                state_r;
  logic [ADDR_WIDTH-1:0] mem_addr_r [FIFO_DEPTH];
  logic [DATA_WIDTH-1:0] mem_data_r [FIFO_DEPTH];
  logic [PW-1:0]         wr_ptr_r;
  logic [PW-1:0]         rd_ptr_r;
  logic [CW-1:0]         count_r;
  logic                  push_s;
  logic                  pop_s;
  logic                  rd_pending_s;

  // Accept/drain qualifiers; the full check deliberately uses the pre-edge count
  always_comb begin
    push_s       = up_rq & up_wr_ni & ~up_ack & (count_r < CW'(FIFO_DEPTH));
    pop_s        = (state_r == WR_REQ) & dn_ack;
    rd_pending_s = up_rq & ~up_wr_ni & ~up_ack;
  end

  assign fill_level = count_r;

  // FIFO storage, no reset needed since occupancy is tracked by count_r
  always_ff @(posedge clk) begin
    if (push_s) begin
      mem_addr_r[wr_ptr_r] <= up_address;
      mem_data_r[wr_ptr_r] <= up_dataW;
    end
  end

  // FIFO pointers and occupancy
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      count_r  <= '0;
    end else begin
      if (push_s) wr_ptr_r <= wr_ptr_r + PW'(1);
      if (pop_s)  rd_ptr_r <= rd_ptr_r + PW'(1);
      case ({push_s, pop_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

  // Downstream FSM with registered handshake outputs on both sides
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r    <= IDLE;
      up_ack     <= 1'b0;
      up_dataR   <= '0;
      dn_address <= '0;
      dn_rq      <= 1'b0;
      dn_wr_ni   <= 1'b0;
      dn_dataW   <= '0;
    end else begin
      up_ack <= push_s;
      case (state_r)
        IDLE: begin
          // Draining posted writes first keeps reads coherent with every earlier write
          if (count_r != '0) begin
            dn_address <= mem_addr_r[rd_ptr_r];
            dn_dataW   <= mem_data_r[rd_ptr_r];
            dn_wr_ni   <= 1'b1;
            dn_rq      <= 1'b1;
            state_r    <= WR_REQ;
          end else if (rd_pending_s) begin
            dn_address <= up_address;
            dn_wr_ni   <= 1'b0;
            dn_rq      <= 1'b1;
            state_r    <= RD_REQ;
          end else begin
            state_r    <= IDLE;
          end
        end
        WR_REQ: begin
          if (dn_ack) begin
            dn_rq   <= 1'b0;
            state_r <= IDLE;
          end
        end
        RD_REQ: begin
          if (dn_ack) begin
            up_dataR <= dn_dataR;
            dn_rq    <= 1'b0;
            up_ack   <= 1'b1;
            state_r  <= RD_RESP;
          end
        end
        RD_RESP: begin
          up_ack  <= 1'b0;
          state_r <= IDLE;
        end
        default: begin
          dn_rq   <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_posted_write_buffer.sv
// Bench for posted_write_buffer: directed scenarios plus randomized traffic checked
// against a queue/array model of posted writes, client-visible memory and RAM contents.
module tb_posted_write_buffer;

  localparam int DW = 8;
  localparam int AW = 4;
  localparam int FD = 4;
  localparam int CW = $clog2(FD+1);

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [AW-1:0] up_address = '0;
  logic          up_rq = 1'b0;
  logic          up_wr_ni = 1'b0;
  logic [DW-1:0] up_dataW = '0;
  logic          up_ack;
  logic [DW-1:0] up_dataR;
  logic [AW-1:0] dn_address;
  logic          dn_rq;
  logic          dn_wr_ni;
  logic [DW-1:0] dn_dataW;
  logic          dn_ack = 1'b0;
  logic [DW-1:0] dn_dataR = '0;
  logic [CW-1:0] fill_level;

  posted_write_buffer #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .FIFO_DEPTH(FD)) dut (
    .clk(clk), .reset(reset),
    .up_address(up_address), .up_rq(up_rq), .up_wr_ni(up_wr_ni), .up_dataW(up_dataW),
    .up_ack(up_ack), .up_dataR(up_dataR),
    .dn_address(dn_address), .dn_rq(dn_rq), .dn_wr_ni(dn_wr_ni), .dn_dataW(dn_dataW),
    .dn_ack(dn_ack), .dn_dataR(dn_dataR), .fill_level(fill_level)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } wr_t;

  int            n_cmp = 0;
  int            n_err = 0;
  logic [DW-1:0] ref_mem [16];
  logic [DW-1:0] ram_mem [16];
  wr_t           model_q [$];
  bit            cur_is_write = 1'b0;
  logic [AW-1:0] cur_addr = '0;
  logic [DW-1:0] cur_data = '0;
  bit            pend_pop = 1'b0;
  bit            ack_given = 1'b0;
  bit            ram_hold = 1'b0;
  bit            expect_quiet = 1'b0;
  int            ram_delay = 0;
  int            wait_cnt = 0;
  int            max_fill = 0;
  int            wr_cnt = 0;
  logic          prev_up_ack = 1'b0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // RAM model and cycle-level monitor, sampling on the falling edge
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        model_q.delete();
        pend_pop = 1'b0;
        ack_given = 1'b0;
        wait_cnt = 0;
        dn_ack = 1'b0;
        prev_up_ack = 1'b0;
        check_eq("rst_fill", fill_level, 0);
        check_eq("rst_dn_rq", dn_rq, 0);
        check_eq("rst_up_ack", up_ack, 0);
      end else begin
        if (up_ack) check_eq("ack_width", prev_up_ack, 0);
        if (up_ack && cur_is_write) begin
          model_q.push_back({cur_addr, cur_data});
          ref_mem[cur_addr] = cur_data;
        end
        if (pend_pop) begin
          if (model_q.size() > 0) void'(model_q.pop_front());
          pend_pop = 1'b0;
        end
        check_eq("fill_level", fill_level, model_q.size());
        if (int'(fill_level) > max_fill) max_fill = int'(fill_level);
        if (ack_given) check_eq("dn_rq_drop", dn_rq, 0);
        ack_given = 1'b0;
        if (expect_quiet) check_eq("quiet_dn_rq", dn_rq, 0);
        if (dn_rq && !ram_hold) begin
          if (wait_cnt >= ram_delay) begin
            if (dn_wr_ni) begin
              check_eq("dn_wr_pending", model_q.size() > 0, 1);
              if (model_q.size() > 0) begin
                check_eq("dn_wr_addr", dn_address, model_q[0].a);
                check_eq("dn_wr_data", dn_dataW, model_q[0].d);
              end
              ram_mem[dn_address] = dn_dataW;
              pend_pop = 1'b1;
              wr_cnt++;
            end else begin
              check_eq("rd_fifo_empty", fill_level, 0);
              check_eq("rd_model_empty", model_q.size(), 0);
              check_eq("dn_rd_addr", dn_address, cur_addr);
              dn_dataR = ram_mem[dn_address];
            end
            dn_ack = 1'b1;
            ack_given = 1'b1;
            wait_cnt = 0;
          end else begin
            wait_cnt++;
          end
        end
        prev_up_ack = up_ack;
      end
      @(posedge clk);
      #1 dn_ack = 1'b0;
    end
  end

  // One upstream transaction; call at posedge+1, returns at posedge+1
  task automatic do_req(input bit wr, input logic [AW-1:0] a, input logic [DW-1:0] d,
                        input int exp_lat);
    int lat;
    cur_is_write = wr;
    cur_addr = a;
    cur_data = d;
    up_wr_ni = wr;
    up_address = a;
    up_dataW = d;
    up_rq = 1'b1;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!up_ack && lat < 200);
    check_eq(wr ? "wr_ack_seen" : "rd_ack_seen", up_ack, 1);
    if (up_ack && !wr) check_eq("rd_data", up_dataR, ref_mem[a]);
    if (up_ack && exp_lat > 0) check_eq(wr ? "wr_latency" : "rd_latency", lat, exp_lat);
    @(posedge clk);
    #1 up_rq = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while ((fill_level != 0 || dn_rq) && n < 300);
    check_eq("drain_done", {dn_rq, fill_level}, 0);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int wr_base;
    int three_idx;
    int idx;
    for (int i = 0; i < 16; i++) begin
      ram_mem[i] = DW'($urandom);
      ref_mem[i] = ram_mem[i];
    end
    repeat (3) @(posedge clk);
    #1 reset = 1'b1;

    // Write burst against a 3-cycle RAM
    ram_delay = 3;
    max_fill = 0;
    wr_base = wr_cnt;
    for (int i = 0; i < 4; i++) do_req(1'b1, AW'(i * 4), DW'((i + 1) * 8'h11), 2);
    check_eq("burst_fill_max", max_fill >= 3, 1);
    wait_drain();
    check_eq("burst_drained", wr_cnt - wr_base, 4);

    // FIFO full: RAM stalled, fifth write held off until the first pop
    ram_hold = 1'b1;
    ram_delay = 0;
    for (int i = 0; i < 4; i++) do_req(1'b1, AW'(i + 1), DW'(8'h80 + i), 2);
    cur_is_write = 1'b1; cur_addr = 4'd13; cur_data = 8'h99;
    up_wr_ni = 1'b1; up_address = 4'd13; up_dataW = 8'h99; up_rq = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq("full_no_ack", up_ack, 0);
      check_eq("full_level", fill_level, 4);
    end
    @(posedge clk);
    #1 ram_hold = 1'b0;
    three_idx = -10;
    idx = 0;
    do begin
      @(negedge clk);
      idx++;
      if (fill_level == 3 && three_idx < 0) three_idx = idx;
    end while (!up_ack && idx < 50);
    check_eq("full_ack_after_pop", idx, three_idx + 1);
    @(posedge clk);
    #1 up_rq = 1'b0;
    wait_drain();

    // Read-after-write to the same address
    ram_delay = 1;
    do_req(1'b1, 4'd6, 8'hA5, 2);
    do_req(1'b0, 4'd6, 8'h00, 0);
    check_eq("raw_value", up_dataR, 8'hA5);

    // Read on an empty FIFO with a zero-latency RAM
    ram_delay = 0;
    ram_mem[9] = 8'h3C;
    ref_mem[9] = 8'h3C;
    wait_drain();
    do_req(1'b0, 4'd9, 8'h00, 3);
    check_eq("empty_rd_value", up_dataR, 8'h3C);
    @(negedge clk);
    check_eq("rd_ack_one_cycle", up_ack, 0);
    @(posedge clk);
    #1;

    // Pointer wrap-around
    ram_delay = 1;
    for (int i = 0; i < 10; i++) do_req(1'b1, AW'(i), DW'(i + 8'h40), 2 * (i % 2 == 0));
    for (int i = 0; i < 10; i++) begin
      do_req(1'b0, AW'(i), 8'h00, 0);
      check_eq("wrap_value", up_dataR, DW'(i + 8'h40));
    end

    // Reset in the middle of a drain
    ram_hold = 1'b1;
    for (int i = 0; i < 3; i++) do_req(1'b1, AW'(i + 10), DW'(8'hC0 + i), 2);
    @(negedge clk);
    check_eq("pre_rst_dn_rq", dn_rq, 1);
    @(posedge clk);
    #3 reset = 1'b0;
    #1;
    check_eq("async_dn_rq", dn_rq, 0);
    check_eq("async_up_ack", up_ack, 0);
    check_eq("async_fill", fill_level, 0);
    for (int i = 0; i < 16; i++) ref_mem[i] = ram_mem[i];
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    ram_hold = 1'b0;
    expect_quiet = 1'b1;
    repeat (6) @(negedge clk);
    expect_quiet = 1'b0;
    @(posedge clk);
    #1;

    // Randomized traffic
    for (int k = 0; k < 150; k++) begin
      ram_delay = $urandom_range(0, 3);
      do_req(1'(($urandom_range(0, 99)) < 60), AW'($urandom), DW'($urandom), 0);
      repeat ($urandom_range(0, 2)) begin
        @(posedge clk);
        #1;
      end
    end
    wait_drain();
    for (int i = 0; i < 16; i++) check_eq("final_ram", ram_mem[i], ref_mem[i]);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
